// File: rtl/ex_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_pkg
// Shared OpenMIPS pipeline definitions used by the EX/MEM pipeline register
// and by ctrl: reset/write-enable encodings, zero constants, the ALU opcode
// width, stall-vector bit positions, and the per-cycle update action decode
// of the EX/MEM register.
// ---------------------------------------------------------------------------
package ex_mem_stage_pkg;

    // Base widths of the core.
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned ALUOP_W        = 8;
    localparam int unsigned CNT_W_DEF      = 2;

    // Control encodings.
    localparam logic RstEnable    = 1'b1;
    localparam logic RstDisable   = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    // Zero constants used as reset/bubble values.
    localparam logic [DATA_W_DEF-1:0]     ZeroWord   = 32'h0000_0000;
    localparam logic [REG_ADDR_W_DEF-1:0] NOPRegAddr = 5'b00000;
    localparam logic [ALUOP_W-1:0]        EXE_NOP_OP = 8'b0000_0000;

    // Bit positions inside the 6-bit stall vector produced by ctrl.
    localparam int unsigned STALL_W       = 6;
    localparam int unsigned STALL_PC_BIT  = 0;
    localparam int unsigned STALL_IF_BIT  = 1;
    localparam int unsigned STALL_ID_BIT  = 2;
    localparam int unsigned STALL_EX_BIT  = 3;
    localparam int unsigned STALL_MEM_BIT = 4;
    localparam int unsigned STALL_WB_BIT  = 5;

    // What the EX/MEM register does on a given clock edge.
    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_HOLD    = 3'd3,
        ACT_ADVANCE = 3'd4
    } stage_act_e;

    // Priority decode: reset, flush, bubble, hold, advance.
    // stall_mem without stall_ex is not produced by ctrl; it falls into hold.
    function automatic stage_act_e sel_action(
        input logic rst,
        input logic flush,
        input logic stall_ex,
        input logic stall_mem
    );
        stage_act_e act;
        if (rst == RstEnable) begin
            act = ACT_RESET;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (stall_ex && !stall_mem) begin
            act = ACT_BUBBLE;
        end else if (stall_mem) begin
            act = ACT_HOLD;
        end else begin
            act = ACT_ADVANCE;
        end
        return act;
    endfunction

endpackage

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline register of the OpenMIPS core with flush, stall-hold and
// bubble insertion. Also keeps the MADD/MSUB partial product and step count
// alive while EX is stalled and feeds them back to EX.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              clear this stage (exception/branch), beats both stalls
//   stall_ex/stall_mem stall bits from ctrl
//   ex_*               fields produced by EX this cycle
//   mem_*              registered fields presented to MEM
//   hilo_temp_o, cnt_o registered multi-cycle accumulator state, back to EX
// All outputs are registered; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned ALUOP_W_P  = ALUOP_W,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_ex,
    input  logic                  stall_mem,

    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [ALUOP_W_P-1:0]  ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   ex_hilo_temp,
    input  logic [CNT_W-1:0]      ex_cnt,

    output logic                  mem_valid,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [ALUOP_W_P-1:0]  mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_temp_o,
    output logic [CNT_W-1:0]      cnt_o
);

    // Reset-value constants sized to the instance parameters.
    localparam logic [REG_ADDR_W-1:0] NOP_WD    = REG_ADDR_W'(NOPRegAddr);
    localparam logic [ALUOP_W_P-1:0]  NOP_ALUOP = ALUOP_W_P'(EXE_NOP_OP);
    localparam logic [DATA_W-1:0]     ZERO_W    = DATA_W'(ZeroWord);
    localparam logic [2*DATA_W-1:0]   ZERO_HILO = '0;
    localparam logic [CNT_W-1:0]      ZERO_CNT  = '0;

    stage_act_e act_c;

    // Action selected for the coming edge.
    always_comb begin
        act_c = sel_action(rst, flush, stall_ex, stall_mem);
    end

    // MEM-side fields: cleared on reset/flush/bubble, held on hold,
    // copied verbatim (even when ex_valid is low) on advance.
    always_ff @(posedge clk) begin
        unique case (act_c)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                mem_valid    <= 1'b0;
                mem_wd       <= NOP_WD;
                mem_wreg     <= WriteDisable;
                mem_wdata    <= ZERO_W;
                mem_whilo    <= WriteDisable;
                mem_hi       <= ZERO_W;
                mem_lo       <= ZERO_W;
                mem_aluop    <= NOP_ALUOP;
                mem_mem_addr <= ZERO_W;
                mem_reg2     <= ZERO_W;
            end
            ACT_ADVANCE: begin
                mem_valid    <= ex_valid;
                mem_wd       <= ex_wd;
                mem_wreg     <= ex_wreg;
                mem_wdata    <= ex_wdata;
                mem_whilo    <= ex_whilo;
                mem_hi       <= ex_hi;
                mem_lo       <= ex_lo;
                mem_aluop    <= ex_aluop;
                mem_mem_addr <= ex_mem_addr;
                mem_reg2     <= ex_reg2;
            end
            default: begin
                mem_valid    <= mem_valid;
                mem_wd       <= mem_wd;
                mem_wreg     <= mem_wreg;
                mem_wdata    <= mem_wdata;
                mem_whilo    <= mem_whilo;
                mem_hi       <= mem_hi;
                mem_lo       <= mem_lo;
                mem_aluop    <= mem_aluop;
                mem_mem_addr <= mem_mem_addr;
                mem_reg2     <= mem_reg2;
            end
        endcase
    end

    // Accumulator feedback: captured only on a bubble (EX repeats the
    // instruction and needs its partial result back), cleared whenever an
    // instruction leaves EX or the stage is flushed/reset.
    always_ff @(posedge clk) begin
        unique case (act_c)
            ACT_BUBBLE: begin
                hilo_temp_o <= ex_hilo_temp;
                cnt_o       <= ex_cnt;
            end
            ACT_RESET, ACT_FLUSH, ACT_ADVANCE: begin
                hilo_temp_o <= ZERO_HILO;
                cnt_o       <= ZERO_CNT;
            end
            default: begin
                hilo_temp_o <= hilo_temp_o;
                cnt_o       <= cnt_o;
            end
        endcase
    end

endmodule
